// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between an add requester and the bit-serial adder.
// The requester drives operands and start; the adder returns status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, input ready, busy, done, sum, cout);
    modport slave  (input start, a, b, output ready, busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell with a registered carry is
// walked LSB to MSB, one bit per clock, then the result is published with done.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             c;

    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic p, g1, s, g2, c_nxt;

    // Two half adders plus an OR form the shared full-adder cell.
    always_comb begin
        p     = a_sr[0] ^ b_sr[0];
        g1    = a_sr[0] & b_sr[0];
        s     = p ^ c;
        g2    = p & c;
        c_nxt = g1 | g2;
        s_nxt = s_sr >> 1;
        s_nxt[WIDTH-1] = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            c       <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        s_sr    <= '0;
                        c       <= 1'b0;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_nxt;
                    c    <= c_nxt;
                    cnt  <= cnt + CW'(1);
                    // Last bit: publish straight from the combinational next value.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        sum_r  <= s_nxt;
                        cout_r <= c_nxt;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1; drivers push
// expected {cout,sum} plus acceptance cycle, monitors pop on each done pulse.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    typedef struct { logic [8:0] exp; int acc; } item8_t;
    typedef struct { logic [1:0] exp; int acc; } item1_t;
    item8_t q8[$];
    item1_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding request.
    logic prev_done8 = 1'b0;
    logic prev_done1 = 1'b0;
    always @(negedge clk) begin
        item8_t it8;
        item1_t it1;
        if (bus8.done === 1'b1) begin
            chk("done8_single_cycle", {31'b0, prev_done8}, 0);
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_unexpected: got done=1 required no pending op");
            end else begin
                it8 = q8.pop_front();
                chk("result8", {23'b0, bus8.cout, bus8.sum}, {23'b0, it8.exp});
                chk("latency8", cyc - it8.acc, 8);
            end
        end
        if (bus1.done === 1'b1) begin
            chk("done1_single_cycle", {31'b0, prev_done1}, 0);
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL done1_unexpected: got done=1 required no pending op");
            end else begin
                it1 = q1.pop_front();
                chk("result1", {30'b0, bus1.cout, bus1.sum}, {30'b0, it1.exp});
                chk("latency1", cyc - it1.acc, 1);
            end
        end
        prev_done8 = bus8.done;
        prev_done1 = bus1.done;
    end

    task automatic wait_ready8(output bit ok);
        int n = 0;
        while (bus8.ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok = (bus8.ready === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready8_timeout: got ready=%b required 1 within 50 cycles", bus8.ready);
        end
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        item8_t it;
        wait_ready8(ok);
        if (!ok) return;
        bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        @(posedge clk); #1;
        it.exp = 9'(a) + 9'(b);
        it.acc = cyc;
        q8.push_back(it);
        chk("busy8_after_accept", {30'b0, bus8.busy, bus8.ready}, 2'b10);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic do_op1(input logic a, input logic b);
        int n = 0;
        item1_t it;
        while (bus1.ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (bus1.ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready1_timeout: got ready=%b required 1", bus1.ready);
            return;
        end
        bus1.a = a; bus1.b = b; bus1.start = 1'b1;
        @(posedge clk); #1;
        it.exp = 2'(a) + 2'(b);
        it.acc = cyc;
        q1.push_back(it);
        chk("busy1_after_accept", {30'b0, bus1.busy, bus1.ready}, 2'b10);
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    initial begin
        bit     ok;
        int     acc1, acc2, n;
        item8_t it;

        rst8 = 1'b1; rst1 = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // {sum,cout,ready,busy,done}
        chk("reset8", {20'b0, bus8.sum, bus8.cout, bus8.ready, bus8.busy, bus8.done}, 12'h004);
        chk("reset1", {27'b0, bus1.sum, bus1.cout, bus1.ready, bus1.busy, bus1.done}, 5'b00100);
        rst8 = 1'b0; rst1 = 1'b0;

        do_op8(8'h00, 8'h00);
        do_op8(8'hFF, 8'h01);
        do_op8(8'hA5, 8'h5A);

        // Previous result must hold while the next op runs.
        do_op8(8'h80, 8'h80);
        chk("hold8_early", {23'b0, bus8.cout, bus8.sum}, 9'h0FF);
        repeat (3) @(negedge clk);
        chk("hold8_late", {23'b0, bus8.cout, bus8.sum}, 9'h0FF);

        // Start held high; operands change mid-run; re-accept exactly 10 cycles later.
        wait_ready8(ok);
        bus8.a = 8'h03; bus8.b = 8'h04; bus8.start = 1'b1;
        @(posedge clk); #1;
        acc1 = cyc;
        it.exp = 9'h007; it.acc = acc1; q8.push_back(it);
        @(negedge clk);
        bus8.a = 8'hFF; bus8.b = 8'hFF;
        n = 0;
        while (bus8.ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        acc2 = cyc;
        chk("reissue_interval", acc2 - acc1, 10);
        it.exp = 9'h1FE; it.acc = acc2; q8.push_back(it);
        @(negedge clk);
        bus8.start = 1'b0;

        // Reset on the 4th RUN edge aborts the op and clears the result.
        wait_ready8(ok);
        bus8.a = 8'h7F; bus8.b = 8'h01; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk); #1;
        // {sum,cout,done,ready}
        chk("abort8", {21'b0, bus8.sum, bus8.cout, bus8.done, bus8.ready}, 11'h001);
        @(negedge clk);
        rst8 = 1'b0;
        chk("abort8_ready", {31'b0, bus8.ready}, 1);
        do_op8(8'h10, 8'h20);

        repeat (1000) do_op8(8'($urandom()), 8'($urandom()));

        do_op1(1'b1, 1'b1);
        do_op1(1'b0, 1'b0);
        do_op1(1'b1, 1'b0);
        do_op1(1'b0, 1'b1);
        repeat (1000) do_op1(1'($urandom()), 1'($urandom()));

        n = 0;
        while ((q8.size() + q1.size()) != 0 && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q8.size() + q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
